// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-memory and memory-macro signals around mem_port_arbiter.
// The arbiter takes the slave view; requesters and the memory macro sit on the master side.
interface mem_port_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    logic            dm_req;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [3:0]      dm_we;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;

    logic            mem_en;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_we;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_we, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_we, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory port between instruction fetch and data memory.
// Define ARB_FAIR_EN to force a fetch grant after MAX_STREAK contested data grants.
module mem_port_arbiter #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_LATENCY = 1
`ifdef ARB_FAIR_EN
    ,
    parameter int unsigned MAX_STREAK  = 4
`endif
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

    typedef enum logic {StIdle, StBusy} state_e;
    typedef enum logic {OwnIf, OwnDm}   owner_e;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            store_q, store_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic resp, can_grant, force_if, gnt_if, gnt_dm;

`ifdef ARB_FAIR_EN
    localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
    logic [StreakW-1:0] streak_q, streak_d;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        // Outputs are forced quiet while reset is high, even before the registers clear.
        resp      = !reset && (state_q == StBusy) && (cnt_q == CntW'(1));
        can_grant = !reset && ((state_q == StIdle) || resp);

        force_if = 1'b0;
`ifdef ARB_FAIR_EN
        force_if = (streak_q == StreakW'(MAX_STREAK)) && bus.if_req && bus.dm_req;
`endif
        gnt_dm = can_grant && bus.dm_req && !force_if;
        gnt_if = can_grant && bus.if_req && !gnt_dm;

        if (state_q == StBusy) begin
            cnt_d = cnt_q - CntW'(1);
            if (resp) state_d = StIdle;
        end

        if (gnt_dm || gnt_if) begin
            state_d = StBusy;
            owner_d = gnt_dm ? OwnDm : OwnIf;
            store_d = gnt_dm && (bus.dm_we != 4'b0000);
            cnt_d   = CntW'(MEM_LATENCY);
            addr_d  = gnt_dm ? bus.dm_addr : bus.if_addr;
            // Fetch has no write data, so mem_wdata keeps its previous value.
            if (gnt_dm) wdata_d = bus.dm_wdata;
        end

`ifdef ARB_FAIR_EN
        streak_d = streak_q;
        if (gnt_if) begin
            streak_d = '0;
        end else if (gnt_dm) begin
            streak_d = bus.if_req ? streak_q + StreakW'(1) : '0;
        end
`endif

        bus.if_gnt    = gnt_if;
        bus.dm_gnt    = gnt_dm;
        bus.mem_en    = gnt_if || gnt_dm;
        bus.mem_we    = gnt_dm ? bus.dm_we : 4'b0000;
        bus.mem_addr  = reset ? '0 : addr_d;
        bus.mem_wdata = reset ? '0 : wdata_d;

        bus.if_rvalid = resp && (owner_q == OwnIf);
        bus.dm_rvalid = resp && (owner_q == OwnDm);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.dm_rdata  = (bus.dm_rvalid && !store_q) ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= OwnIf;
            store_q  <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef ARB_FAIR_EN
            streak_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            store_q  <= store_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef ARB_FAIR_EN
            streak_q <= streak_d;
`endif
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single synchronous memory port between two requesters: instruction fetch (read-only) and the data-memory stage (load/store with byte enables).
- Sits between the datapath's fetch and memory stages and the memory macro.
- Sequences one transaction at a time and tracks the fixed memory read latency.
- Returns the response to the owning requester; the pipeline stalls on missing grant/valid.

Parameters:
- XLEN, 32, address/data width (matches `XLEN)
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal 1..4
- MAX_STREAK, 4, consecutive contested data grants before fetch is forced (fairness feature only); legal 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  XLEN  fetch word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse, fetch data valid
- if_rdata  out  XLEN  fetch data
- dm_req  in  1  data request; held with addr/wdata/we until dm_gnt
- dm_addr  in  XLEN  data address
- dm_wdata  in  XLEN  store data
- dm_we  in  4  byte write enables; 4'b0000 = load
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  one-cycle pulse, load data valid / store complete
- dm_rdata  out  XLEN  load data; 0 for stores
- mem_en  out  1  memory access strobe
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_we  out  4  memory byte enables
- mem_rdata  in  XLEN  memory read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- State: IDLE / BUSY, plus owner register (IF/DM), store flag, and latency counter (width to hold MEM_LATENCY).
- Reset (any cycle, including mid-transaction): state IDLE, counter 0, streak 0.
  - All outputs 0: gnt, rvalid, mem_en, mem_we, rdata, mem_addr, mem_wdata.
  - An outstanding transaction is dropped; no rvalid is ever issued for it.
- Grant cycle:
  - Allowed when state IDLE, or in the BUSY response cycle.
  - Exactly one of if_gnt/dm_gnt is asserted, combinationally from the requests.
  - In the same cycle, mem_en=1 and mem_addr/mem_wdata/mem_we are driven from the winner.
  - mem_we is forced to 0 for fetch.
  - Then: state BUSY, owner latched, counter loaded with MEM_LATENCY.
- Priority: dm wins over if when both request (default; the older instruction keeps draining).
- BUSY:
  - Counter decrements each cycle.
  - Response cycle = exactly MEM_LATENCY cycles after the grant cycle.
  - In the response cycle the owner's rvalid=1 and rdata=mem_rdata; dm_rdata=0 for stores.
  - The non-owner's rvalid stays 0.
  - If no new grant occurs in the response cycle, return to IDLE.
- Throughput: one transaction per MEM_LATENCY cycles under back-to-back requests. With MEM_LATENCY=1, a grant every cycle.
- Outside the grant cycle: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last value.
- Each gnt covers exactly one transaction. A requester holding req after gnt is treated as a new request.
- rdata outputs are 0 when the corresponding rvalid=0.
- No req while BUSY (except in the response cycle) produces a grant; requests wait.

Optional Feature:
- Macro: ARB_FAIR_EN
- Defined:
  - A streak counter increments on each dm grant made while if_req=1.
  - When streak==MAX_STREAK and both request, fetch wins and streak clears.
  - Streak also clears on any if grant, or on a dm grant with if_req=0.
- Undefined: strict dm priority; streak logic absent; fetch can starve indefinitely.

Test Plan:
- Reset check: MEM_LATENCY=2, hold reset 3 cycles with both reqs high -> all outputs 0, no gnt. Release -> dm_gnt in the first cycle.
- Fetch alone: MEM_LATENCY=2, if_req with if_addr=0x100 at cycle t -> if_gnt, mem_en, mem_addr=0x100, mem_we=0 at t. if_rvalid with mem_rdata at t+2. dm_rvalid stays 0.
- Contention: MEM_LATENCY=1, both request at t -> dm_gnt at t, if_gnt at t+1. dm_rvalid at t+1, if_rvalid at t+2.
- Store: dm_we=4'b0011, dm_addr=0x2000, dm_wdata=0xDEADBEEF -> mem_we=0011, mem_wdata=0xDEADBEEF in the grant cycle. dm_rvalid after MEM_LATENCY with dm_rdata=0.
- Reset mid-op: MEM_LATENCY=3, reset asserted 1 cycle after a fetch grant -> no if_rvalid ever appears. Next if_req is granted normally.
- Fairness: MEM_LATENCY=1, MAX_STREAK=4, both reqs held high.
  - With ARB_FAIR_EN: grants DM,DM,DM,DM,IF,DM….
  - Without ARB_FAIR_EN: DM on every cycle, if_gnt never asserted.
